// File: rtl/mc_sequencer.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB sequencer sharing one memory port.
// Ports: decoded controls in, memory/ALU handshakes, datapath enables out, halted, retired count.
module mc_sequencer #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             RegWrite,
  input  logic             MemRead,
  input  logic             MemWrite,
  input  logic             Branch,
  input  logic             Jump,
  input  logic             JumpReg,
  input  logic             is_syscall,
  input  logic             alu_multicycle,
  input  logic             alu_done,
  input  logic             alu_zero,
  input  logic             mem_ready,
  output logic             mem_req,
  output logic             mem_we,
  output logic             mem_addr_sel,
  output logic             ir_load,
  output logic             alu_start,
  output logic             reg_we,
  output logic             pc_load,
  output logic [1:0]       pc_src,
  output logic             halted,
  output logic [CNT_W-1:0] retired
);

  typedef enum logic [2:0] {
    START, FETCH, DECODE, EXEC, MEM, WB, HALT
  } state_t;

  state_t state;
  state_t nxt;

  logic rw_q;
  logic mr_q;
  logic mw_q;
  logic br_q;
  logic jp_q;
  logic jr_q;
  logic mc_q;
  logic zero_q;
  logic first_q;
  logic exec_end;

  // first_q marks the start cycle of EXEC; alu_done is ignored there.
  always_comb begin
    exec_end = (state == EXEC) &&
               (!mc_q || (!first_q && alu_done));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= START;
      rw_q    <= 1'b0;
      mr_q    <= 1'b0;
      mw_q    <= 1'b0;
      br_q    <= 1'b0;
      jp_q    <= 1'b0;
      jr_q    <= 1'b0;
      mc_q    <= 1'b0;
      zero_q  <= 1'b0;
      first_q <= 1'b0;
      retired <= '0;
    end else begin
      state   <= nxt;
      first_q <= (state == DECODE);
      if (state == DECODE) begin
        rw_q <= RegWrite;
        mr_q <= MemRead;
        mw_q <= MemWrite;
        br_q <= Branch;
        jp_q <= Jump;
        jr_q <= JumpReg;
        mc_q <= alu_multicycle;
      end
      if (exec_end) begin
        zero_q <= alu_zero;
      end
      if (state == WB) begin
        retired <= retired + {{(CNT_W-1){1'b0}}, 1'b1};
      end
    end
  end

  always_comb begin
    nxt          = state;
    mem_req      = 1'b0;
    mem_we       = 1'b0;
    mem_addr_sel = 1'b0;
    ir_load      = 1'b0;
    alu_start    = 1'b0;
    reg_we       = 1'b0;
    pc_load      = 1'b0;
    pc_src       = 2'b00;
    halted       = 1'b0;
    case (state)
      START: begin
        nxt = FETCH;
      end
      FETCH: begin
        mem_req = 1'b1;
        if (mem_ready) begin
          ir_load = 1'b1;
          nxt     = DECODE;
        end
      end
      DECODE: begin
        nxt = is_syscall ? HALT : EXEC;
      end
      EXEC: begin
        alu_start = mc_q && first_q;
        if (exec_end) begin
          nxt = (mr_q || mw_q) ? MEM : WB;
        end
      end
      MEM: begin
        mem_req      = 1'b1;
        mem_addr_sel = 1'b1;
        mem_we       = mw_q;
        if (mem_ready) begin
          nxt = WB;
        end
      end
      WB: begin
        reg_we  = rw_q;
        pc_load = 1'b1;
        if (jr_q) begin
          pc_src = 2'b11;
        end else if (jp_q) begin
          pc_src = 2'b10;
        end else if (br_q && zero_q) begin
          pc_src = 2'b01;
        end
        nxt = FETCH;
      end
      HALT: begin
        halted = 1'b1;
      end
      default: begin
        nxt = START;
      end
    endcase
  end

endmodule

// File: tb/tb_mc_sequencer.sv
// Directed bench for mc_sequencer: per-instruction cycle traces
// checked against hand-derived expectations.
module tb_mc_sequencer;

  logic        clk;
  logic        rst_n;
  logic        RegWrite, MemRead, MemWrite;
  logic        Branch, Jump, JumpReg;
  logic        is_syscall, alu_multicycle;
  logic        alu_done, alu_zero, mem_ready;
  logic        mem_req, mem_we, mem_addr_sel;
  logic        ir_load, alu_start, reg_we, pc_load;
  logic [1:0]  pc_src;
  logic        halted;
  logic [31:0] retired;

  int total;
  int bad;

  logic       t_req [64];
  logic       t_we  [64];
  logic       t_sel [64];
  logic       t_ir  [64];
  logic       t_st  [64];
  logic       t_rwe [64];
  logic       t_pcl [64];
  logic [1:0] t_src [64];
  logic       t_hlt [64];

  mc_sequencer #(.CNT_W(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .RegWrite(RegWrite), .MemRead(MemRead),
    .MemWrite(MemWrite), .Branch(Branch),
    .Jump(Jump), .JumpReg(JumpReg),
    .is_syscall(is_syscall),
    .alu_multicycle(alu_multicycle),
    .alu_done(alu_done), .alu_zero(alu_zero),
    .mem_ready(mem_ready), .mem_req(mem_req),
    .mem_we(mem_we), .mem_addr_sel(mem_addr_sel),
    .ir_load(ir_load), .alu_start(alu_start),
    .reg_we(reg_we), .pc_load(pc_load),
    .pc_src(pc_src), .halted(halted),
    .retired(retired)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Runs one instruction from FETCH, playing memory (fw/mwt wait
  // cycles) and iterative ALU (done k cycles after start).
  task automatic run(
    input logic rw, mr, mw, br, jp, jr, sc, mc, z,
    input int fw, mwt, k, early,
    output int n
  );
    int cnt;
    int since;
    bit started;
    RegWrite = rw; MemRead = mr; MemWrite = mw;
    Branch = br; Jump = jp; JumpReg = jr;
    is_syscall = sc; alu_multicycle = mc; alu_zero = z;
    cnt = 0; since = 0; started = 0; n = 0;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      if (started) since++;
      alu_done = (started && since == k) ||
                 (early != 0 && alu_start);
      if (mem_req) begin
        mem_ready = (cnt >= (mem_addr_sel ? mwt : fw));
        cnt++;
      end else begin
        mem_ready = 1'b0;
        cnt = 0;
      end
      #1;
      t_req[c] = mem_req;  t_we[c]  = mem_we;
      t_sel[c] = mem_addr_sel; t_ir[c] = ir_load;
      t_st[c]  = alu_start; t_rwe[c] = reg_we;
      t_pcl[c] = pc_load;  t_src[c] = pc_src;
      t_hlt[c] = halted;
      if (mem_ready) cnt = 0;
      if (alu_start) begin started = 1; since = 0; end
      n = c;
      if (pc_load || halted) break;
    end
    @(posedge clk);
    #1;
    mem_ready = 1'b0;
    alu_done = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    RegWrite = 0; MemRead = 0; MemWrite = 0;
    Branch = 0; Jump = 0; JumpReg = 0;
    is_syscall = 0; alu_multicycle = 0;
    alu_done = 0; alu_zero = 0; mem_ready = 0;
    repeat (2) @(negedge clk);
    total++;
    if ({mem_req, mem_we, mem_addr_sel, ir_load, alu_start,
         reg_we, pc_load, pc_src, halted} !== 10'd0) begin
      bad++;
      $display("FAIL reset_outs got=%b exp=0",
        {mem_req, mem_we, mem_addr_sel, ir_load, alu_start,
         reg_we, pc_load, pc_src, halted});
    end
    total++;
    if (retired !== 32'd0) begin
      bad++;
      $display("FAIL reset_retired got=%0d exp=0", retired);
    end
    @(posedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    total++;
    if ({mem_req, pc_load, halted} !== 3'b000) begin
      bad++;
      $display("FAIL start_idle got=%b exp=000",
        {mem_req, pc_load, halted});
    end
  endtask

  task automatic test_add();
    int n;
    int reqs;
    run(1,0,0,0,0,0,0,0,0, 0,0,0,0, n);
    total++;
    if (n !== 4) begin
      bad++; $display("FAIL add_len got=%0d exp=4", n);
    end
    reqs = 0;
    for (int i = 1; i <= n; i++) reqs += int'(t_req[i]);
    total++;
    if (t_req[1] !== 1'b1 || t_ir[1] !== 1'b1 || reqs !== 1) begin
      bad++;
      $display("FAIL add_fetch got=%b%b/%0d exp=11/1",
        t_req[1], t_ir[1], reqs);
    end
    total++;
    if ({t_rwe[4], t_pcl[4], t_src[4]} !== 4'b1100) begin
      bad++;
      $display("FAIL add_wb got=%b exp=1100",
        {t_rwe[4], t_pcl[4], t_src[4]});
    end
    total++;
    if (retired !== 32'd1) begin
      bad++; $display("FAIL add_retired got=%0d exp=1", retired);
    end
  endtask

  task automatic test_lw();
    int n;
    int reqs;
    run(1,1,0,0,0,0,0,0,0, 3,3,0,0, n);
    total++;
    if (n !== 11) begin
      bad++; $display("FAIL lw_len got=%0d exp=11", n);
    end
    reqs = 0;
    for (int i = 1; i <= n; i++) reqs += int'(t_req[i]);
    total++;
    if (reqs !== 8) begin
      bad++; $display("FAIL lw_reqs got=%0d exp=8", reqs);
    end
    total++;
    if ({t_sel[1], t_sel[4], t_ir[3], t_ir[4]} !== 4'b0001) begin
      bad++;
      $display("FAIL lw_fetch got=%b exp=0001",
        {t_sel[1], t_sel[4], t_ir[3], t_ir[4]});
    end
    total++;
    if ({t_req[7], t_sel[7], t_we[7], t_sel[10], t_we[10]}
        !== 5'b11010) begin
      bad++;
      $display("FAIL lw_mem got=%b exp=11010",
        {t_req[7], t_sel[7], t_we[7], t_sel[10], t_we[10]});
    end
    total++;
    if ({t_rwe[11], t_pcl[11], t_src[11]} !== 4'b1100) begin
      bad++;
      $display("FAIL lw_wb got=%b exp=1100",
        {t_rwe[11], t_pcl[11], t_src[11]});
    end
    total++;
    if (retired !== 32'd2) begin
      bad++; $display("FAIL lw_retired got=%0d exp=2", retired);
    end
  endtask

  task automatic test_branch();
    int n;
    run(0,0,0,1,0,0,0,0,1, 0,0,0,0, n);
    total++;
    if (n !== 4 || {t_rwe[4], t_pcl[4], t_src[4]} !== 4'b0101) begin
      bad++;
      $display("FAIL beq_taken got=%0d/%b exp=4/0101",
        n, {t_rwe[4], t_pcl[4], t_src[4]});
    end
    run(0,0,0,1,0,0,0,0,0, 0,0,0,0, n);
    total++;
    if (n !== 4 || {t_rwe[4], t_pcl[4], t_src[4]} !== 4'b0100) begin
      bad++;
      $display("FAIL beq_not got=%0d/%b exp=4/0100",
        n, {t_rwe[4], t_pcl[4], t_src[4]});
    end
    total++;
    if (retired !== 32'd4) begin
      bad++; $display("FAIL beq_retired got=%0d exp=4", retired);
    end
  endtask

  task automatic test_jump();
    int n;
    run(0,0,0,1,1,1,0,0,1, 0,0,0,0, n);
    total++;
    if (n !== 4 || t_src[4] !== 2'b11) begin
      bad++;
      $display("FAIL jr_src got=%0d/%b exp=4/11", n, t_src[4]);
    end
    run(0,0,0,1,1,0,0,0,1, 0,0,0,0, n);
    total++;
    if (n !== 4 || t_src[4] !== 2'b10) begin
      bad++;
      $display("FAIL j_src got=%0d/%b exp=4/10", n, t_src[4]);
    end
  endtask

  task automatic test_mult();
    int n;
    int starts;
    run(1,0,0,0,0,0,0,1,0, 0,0,5,1, n);
    total++;
    if (n !== 9) begin
      bad++; $display("FAIL mult_len got=%0d exp=9", n);
    end
    starts = 0;
    for (int i = 1; i <= n; i++) starts += int'(t_st[i]);
    total++;
    if (starts !== 1 || t_st[3] !== 1'b1) begin
      bad++;
      $display("FAIL mult_start got=%0d/%b exp=1/1", starts, t_st[3]);
    end
    total++;
    if ({t_rwe[9], t_pcl[9]} !== 2'b11) begin
      bad++;
      $display("FAIL mult_wb got=%b exp=11", {t_rwe[9], t_pcl[9]});
    end
    total++;
    if (retired !== 32'd7) begin
      bad++; $display("FAIL mult_retired got=%0d exp=7", retired);
    end
  endtask

  task automatic test_abort();
    bit found;
    RegWrite = 1; MemRead = 1; MemWrite = 0;
    Branch = 0; Jump = 0; JumpReg = 0;
    is_syscall = 0; alu_multicycle = 0;
    found = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      mem_ready = mem_req && !mem_addr_sel;
      #1;
      if (mem_req && mem_addr_sel) begin
        found = 1;
        break;
      end
    end
    total++;
    if (!found) begin
      bad++; $display("FAIL abort_reach_mem got=0 exp=1");
    end
    #1 rst_n = 1'b0;
    #1;
    total++;
    if ({mem_req, mem_we, mem_addr_sel} !== 3'b000 ||
        retired !== 32'd0) begin
      bad++;
      $display("FAIL abort_async got=%b/%0d exp=000/0",
        {mem_req, mem_we, mem_addr_sel}, retired);
    end
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    total++;
    if ({mem_req, pc_load, reg_we} !== 3'b000) begin
      bad++;
      $display("FAIL abort_start got=%b exp=000",
        {mem_req, pc_load, reg_we});
    end
    @(negedge clk);
    #1;
    total++;
    if ({mem_req, mem_addr_sel} !== 2'b10 || retired !== 32'd0) begin
      bad++;
      $display("FAIL abort_fetch got=%b/%0d exp=10/0",
        {mem_req, mem_addr_sel}, retired);
    end
  endtask

  task automatic test_sw_halt();
    int n;
    run(0,0,1,0,0,0,0,0,0, 0,0,0,0, n);
    total++;
    if (n !== 5) begin
      bad++; $display("FAIL sw_len got=%0d exp=5", n);
    end
    total++;
    if ({t_req[4], t_sel[4], t_we[4], t_rwe[5], t_pcl[5]}
        !== 5'b11101) begin
      bad++;
      $display("FAIL sw_mem got=%b exp=11101",
        {t_req[4], t_sel[4], t_we[4], t_rwe[5], t_pcl[5]});
    end
    run(0,0,0,0,0,0,1,0,0, 0,0,0,0, n);
    total++;
    if (n !== 3 || t_hlt[3] !== 1'b1 || t_req[3] !== 1'b0) begin
      bad++;
      $display("FAIL sys_halt got=%0d/%b%b exp=3/10",
        n, t_hlt[3], t_req[3]);
    end
    is_syscall = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      mem_ready = 1'b1;
      total++;
      if ({halted, mem_req, pc_load, reg_we} !== 4'b1000 ||
          retired !== 32'd1) begin
        bad++;
        $display("FAIL halt_frozen cyc=%0d got=%b/%0d exp=1000/1",
          c, {halted, mem_req, pc_load, reg_we}, retired);
      end
    end
    mem_ready = 1'b0;
  endtask

  initial begin
    total = 0;
    bad = 0;
    test_reset();
    test_add();
    test_lw();
    test_branch();
    test_jump();
    test_mult();
    test_abort();
    test_sw_halt();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule
